// File: rtl/branch_ctrl.sv
// Branch/PC sequencing controller: owns the fetch PC, resolves B/BR in ID,
// stalls on flag/register hazards, handles HLT and keeps branch statistics.
module branch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_instr,
    input  logic             id_valid,
    input  logic [15:0]      id_pc_plus2,
    input  logic [15:0]      id_reg_target,
    input  logic [2:0]       flags_stored,
    input  logic             ex_flag_write,
    input  logic             ex_reg_hazard,
    input  logic             fetch_stall,
    output logic [15:0]      pc,
    output logic             ifid_flush,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             branch_taken,
    output logic             halted,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_nx;
    logic [15:0] pc_nx;
    logic [15:0] b_off;
    logic [15:0] target;
    logic [3:0]  op;
    logic [2:0]  cc;
    logic        n, z, v;
    logic        is_b, is_br, is_hlt, is_bx;
    logic        hz, cond, resolve;

    assign op     = id_instr[15:12];
    assign cc     = id_instr[11:9];
    assign n      = flags_stored[2];
    assign z      = flags_stored[1];
    assign v      = flags_stored[0];
    assign is_b   = id_valid && (op == 4'b1100);
    assign is_br  = id_valid && (op == 4'b1101);
    assign is_hlt = id_valid && (op == 4'b1111);
    assign is_bx  = is_b || is_br;
    assign hz     = (is_bx && ex_flag_write) || (is_br && ex_reg_hazard);
    assign b_off  = {{6{id_instr[8]}}, id_instr[8:0], 1'b0};
    assign target = is_br ? id_reg_target : id_pc_plus2 + b_off;
    assign halted = (state == HALT);

    always_comb begin
        cond = 1'b0;
        unique case (cc)
            3'b000: cond = !z;
            3'b001: cond = z;
            3'b010: cond = !z && !n;
            3'b011: cond = n;
            3'b100: cond = z || !n;
            3'b101: cond = n || z;
            3'b110: cond = v;
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // RUN and STALL share behaviour; STALL only records that ID is held.
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        ifid_flush   = 1'b0;
        ifid_stall   = 1'b0;
        idex_bubble  = 1'b0;
        branch_taken = 1'b0;
        resolve      = 1'b0;
        unique case (state)
            HALT: begin
                ifid_stall = 1'b1;
            end
            RUN, STALL: begin
                if (hz) begin
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    state_nx    = STALL;
                end else if (is_hlt) begin
                    ifid_flush = 1'b1;
                    state_nx   = HALT;
                end else begin
                    state_nx = RUN;
                    resolve  = is_bx;
                    if (is_bx && cond) begin
                        branch_taken = 1'b1;
                        ifid_flush   = 1'b1;
                        pc_nx        = target;
                    end else if (!fetch_stall) begin
                        pc_nx = pc + 16'd2;
                    end
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (resolve && branch_count != '1)
                branch_count <= branch_count + CNT_ONE;
            if (branch_taken && taken_count != '1)
                taken_count <= taken_count + CNT_ONE;
        end
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch and PC sequencing controller for the WISC pipeline. It owns the PC register and resolves B and BR instructions in the ID stage against the stored NZV flags. It stalls ID when a branch depends on flags or a register still in flight, and redirects fetch with a one-cycle IF/ID flush on taken branches. It also handles HLT entry and keeps saturating branch statistics counters.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- CNT_W, 16, width of statistics counters

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- id_instr  input  16  instruction currently in ID
- id_valid  input  1  ID holds a real instruction (not a bubble)
- id_pc_plus2  input  16  address of the ID instruction + 2
- id_reg_target  input  16  register-file value of rs for BR (id_instr[7:4])
- flags_stored  input  3  architectural flags {N,Z,V}
- ex_flag_write  input  1  instruction in EX writes flags at end of this cycle
- ex_reg_hazard  input  1  rs of ID instruction is the destination of an instruction in EX or MEM
- fetch_stall  input  1  fetch not ready (I-cache miss); PC must not advance
- pc  output  16  fetch address, registered
- ifid_flush  output  1  squash IF/ID contents at next edge
- ifid_stall  output  1  hold IF/ID and PC this cycle
- idex_bubble  output  1  insert NOP into ID/EX at next edge
- branch_taken  output  1  taken branch resolved this cycle
- halted  output  1  core halted, registered, sticky until rst
- branch_count  output  CNT_W  resolved branches, saturating
- taken_count  output  CNT_W  taken branches, saturating

## Operation
- Decode, valid only when id_valid=1:
  - B: id_instr[15:12]=4'b1100.
  - BR: id_instr[15:12]=4'b1101.
  - HLT: id_instr[15:12]=4'b1111.
  - Condition code cc = id_instr[11:9].
- Condition met, by cc:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 and N=0
  - 011: N=1
  - 100: Z=1 or (Z=0 and N=0)
  - 101: N=1 or Z=1
  - 110: V=1
  - 111: always
- Branch targets:
  - B: id_pc_plus2 + (sign-extended id_instr[8:0] << 1), modulo 2^16.
  - BR: id_reg_target.
- Hazards:
  - flag_hz = (B or BR) and ex_flag_write.
  - reg_hz = BR and ex_reg_hazard.
  - hz = flag_hz or reg_hz.
- State machine, states RUN, STALL, HALT:
  - RUN: if hz, go to STALL and hold. Else if HLT, go to HALT. Else resolve the branch, if any, and stay in RUN.
  - STALL: hz is re-evaluated each cycle; remain in STALL while hz=1. When hz=0, resolve in that same cycle and return to RUN, or go to HALT on HLT.
  - HALT: absorbing; left only by rst.
- While hz=1 (RUN or STALL):
  - ifid_stall=1, idex_bubble=1.
  - PC holds; nothing resolves and no counter moves.
- Resolution, when hz=0 and the instruction is B or BR:
  - branch_count increments.
  - If the condition is met: branch_taken=1, ifid_flush=1, PC loads the target next edge, and taken_count increments.
  - If the condition is not met: PC follows normal sequencing.
- Normal sequencing: PC = PC + 2 when fetch_stall=0; hold when fetch_stall=1.
- Redirect priority:
  - A taken branch loads the target even if fetch_stall=1; the fetch unit abandons the miss.
  - Priority order: rst > HALT hold > hazard hold > redirect > fetch_stall hold > PC + 2.
- HLT, when hz=0:
  - ifid_flush=1 for one cycle and PC holds.
  - halted=1 from next edge. In HALT, PC frozen, ifid_flush=0, ifid_stall=1.
- Counters saturate at all-ones; never wrap.
- Reset values:
  - pc=RESET_PC, state=RUN, halted=0, branch_count=0, taken_count=0.
  - Reset mid-stall or in HALT returns to RUN immediately.

## Timing
- Registered outputs: pc, halted, branch_count, taken_count.
- Combinational outputs, in the same cycle as the ID instruction: ifid_flush, ifid_stall, idex_bubble, branch_taken.
- Resolution latency:
  - 0 cycles after the instruction reaches ID with hz=0.
  - PC shows the target 1 edge later.
  - Taken branch costs exactly 1 squashed fetch.
- Flag-hazard stall is normally 1 cycle; the flag writer leaves EX and the bubble behind it clears ex_flag_write. Length still tracks the inputs exactly.
- Counters update at the edge ending the resolving cycle.
- In STALL, the counters and branch_taken are asserted only in the exit cycle, never per stall cycle.
- id_valid=0: no decode, no stall, no counter change; PC follows fetch_stall.

## Test plan
- Reset then free run: rst high 1 cycle, 4 cycles of NOPs -> pc 0000, 0002, 0004, 0006; all counters 0.
- B with cc=001, imm9=9'h1FE, id_pc_plus2=0010, Z=1 -> branch_taken=1, ifid_flush=1, pc=000C next edge, both counters=1.
- Same B with Z=0 -> branch_taken=0, pc=PC+2, branch_count=1, taken_count=0.
- B (cc=010) in ID while ex_flag_write=1 for 1 cycle -> cycle 1: ifid_stall=1, idex_bubble=1, pc held, counters unchanged. Cycle 2: resolves with the updated flags; counters move once.
- BR with ex_reg_hazard=1 for 2 cycles, id_reg_target=1234, cc=111 -> 2 stall cycles, then pc=1234 with fetch_stall=1 held throughout; taken_count=1.
- HLT then rst:
  - HLT at id_pc_plus2=0040 -> 1-cycle flush, halted=1, pc frozen 10 cycles.
  - rst -> halted=0, pc=RESET_PC.
  - Also force taken_count to FFFF and take one more branch -> stays FFFF.
